fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage that sits directly upstream of the single-cycle decode/execute datapath. It owns the fetch PC and issues pipelined word reads to the instruction memory. It buffers up to DEPTH in-order responses, each tagged with its PC, and hands them downstream over a valid/ready handshake. A redirect from the execute stage (JALR or branch target) flushes buffered and in-flight instructions.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2; also the cap on outstanding memory requests
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  read request valid
- imem_addr  out  32  word-aligned read address (current fetch PC)
- imem_gnt  in  1  request accepted this cycle (imem_req && imem_gnt = issue)
- imem_rvalid  in  1  response valid; in order; at least 1 cycle after its grant
- imem_rdata  in  32  response instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored
- inst_valid  out  1  head entry holds a fetched instruction
- inst  out  32  head instruction word
- inst_pc  out  32  PC of head instruction
- inst_ready  in  1  downstream consumes head when inst_valid && inst_ready

## Operation
- Ring of DEPTH entries {pc, word} with three pointers, each one bit wider than the index:
  - tail: allocated at issue, and pc is written at issue.
  - fill: the next entry to receive a response.
  - head: the next entry to pop.
- occupancy = tail − head; pending = tail − fill.
- imem_req = !reset && !redirect && (occupancy + drop_cnt) < DEPTH. Since all counts are registered, imem_req has no combinational path from inst_ready.
- On issue: write entry[tail].pc = fetch_pc; then tail+1 and fetch_pc+4. fetch_pc wraps modulo 2^32.
- On imem_rvalid:
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise: write entry[fill].word = imem_rdata, then fill+1.
- inst_valid = (fill != head). inst and inst_pc read entry[head] and are forced to 0 when inst_valid=0.
- On pop: head+1.
- On redirect (has priority over everything):
  - Set head = fill = tail = 0.
  - Set drop_cnt = drop_cnt + pending − (imem_rvalid && drop_cnt==0 ? 1 : 0), and also −1 if drop_cnt>0 && imem_rvalid.
  - Set fetch_pc = {redirect_pc[31:2], 2'b00}.
  - A simultaneous pop is cancelled, and a simultaneous response belongs to the flushed stream.
- Requests for the new stream may issue from the cycle after redirect, while drops are still being drained. Because responses are in order, drops are always the oldest.
- Total outstanding requests never exceed DEPTH.
- An rvalid arriving with pending==0 and drop_cnt==0 is a protocol violation. The data is ignored; the assertion lives in the bench.

## Timing
- Reset values: fetch_pc=RESET_PC; pointers=0; drop_cnt=0; imem_req=0; imem_addr=RESET_PC; inst_valid=0; inst=0; inst_pc=0.
- First imem_req occurs in the first cycle with reset low.
- Fetch latency:
  - Grant in cycle N with rvalid in N+1 gives inst_valid in N+2.
  - In general, inst_valid rises 1 cycle after the response.
- A pop frees a slot for imem_req in the following cycle.
- Sustained rate is 1 instruction per cycle with 1-cycle memory latency when DEPTH ≥ 3.
- Redirect in cycle R: imem_req=0 in R, and inst_valid=0 in R+1. The first new-stream instruction appears no earlier than R+3.
- Full queue (occupancy+drop_cnt == DEPTH): imem_req=0; the state holds until a pop or a drop.
- Reset asserted mid-operation overrides everything, including in-flight drops. The memory must itself be reset on the same cycle.

## Structure
- Shared package fetch_pkg holds:
  - XLEN=32 and the NOP encoding 32'h0000_0013.
  - The fetch_entry_t struct {pc, word}.
  - Pointer-width localparam derived from DEPTH.
- One sub-module, fetch_ring: DEPTH-entry storage with independent alloc-write (pc), fill-write (word) and head-read ports.
- Pointer, drop counter and fetch-PC logic stay in fetch_queue.

## Test plan
- Reset release, memory always grants with 1-cycle latency, inst_ready=1 → imem_addr runs 0,4,8,…; inst_pc=0 appears 2 cycles after first issue; one instruction per cycle thereafter.
- inst_ready=0 held for 10 cycles → exactly DEPTH=4 issues (PCs 0..12), imem_req drops to 0, and inst/inst_pc hold 0x…/0. Release ready → PCs 0,4,8,12,16 in order.
- Memory latency 3 cycles with 3 requests in flight; redirect to 0x0000_0103 → the next imem_addr is 0x100, the 3 stale responses are discarded, and the first inst_pc out is 0x100.
- Redirect in the same cycle as imem_rvalid and a pop → the pop is cancelled, the response is dropped, and no stale PC ever reaches the output.
- Fetch PC at 0xFFFF_FFF8 via redirect → issues 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted with a full queue and drops pending → next cycle inst_valid=0, imem_req=0, and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          c_XLEN          = 32;
  localparam logic [31:0] c_NOP           = 32'h0000_0013;
  localparam int          c_DEFAULT_DEPTH = 4;

  // One queue slot: the PC captured at issue and the word captured at response
  typedef struct packed {
    logic [c_XLEN-1:0] pc;
    logic [c_XLEN-1:0] word;
  } fetch_entry_t;

  // Ring pointers carry one extra wrap bit above the index
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int c_PTR_W = ptr_width(c_DEFAULT_DEPTH);

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Instruction-memory, redirect and decode-side handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [c_XLEN-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [c_XLEN-1:0] imem_rdata;
  logic              redirect;
  logic [c_XLEN-1:0] redirect_pc;
  logic              inst_valid;
  logic [c_XLEN-1:0] inst;
  logic [c_XLEN-1:0] inst_pc;
  logic              inst_ready;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue_ring.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ring
//  Description : DEPTH-entry {pc, word} storage with independent alloc-write,
//                fill-write and head-read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ring
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              i_alloc_we,
  input  wire logic [IDX_W-1:0]  i_alloc_idx,
  input  wire logic [c_XLEN-1:0] i_alloc_pc,
  input  wire logic              i_fill_we,
  input  wire logic [IDX_W-1:0]  i_fill_idx,
  input  wire logic [c_XLEN-1:0] i_fill_word,
  input  wire logic [IDX_W-1:0]  i_head_idx,
  output fetch_entry_t           o_head_entry
);

  logic [c_XLEN-1:0] r_pc   [DEPTH];
  logic [c_XLEN-1:0] r_word [DEPTH];

  // PC is captured when the request issues, the word when its response lands
  always_ff @(posedge clk) begin
    if (i_alloc_we) r_pc[i_alloc_idx]  <= i_alloc_pc;
    if (i_fill_we)  r_word[i_fill_idx] <= i_fill_word;
  end

  // Head read is combinational so the entry is visible in the same cycle
  always_comb begin
    o_head_entry      = '0;
    o_head_entry.pc   = r_pc[i_head_idx];
    o_head_entry.word = r_word[i_head_idx];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Fetch stage: owns the fetch PC, issues pipelined word reads,
//                buffers in-order responses tagged with their PC and flushes
//                buffered and in-flight work on a redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic      clk,
  input  wire logic      reset,
  fetch_queue_if.master  bus
);

  localparam int c_PTR_W = ptr_width(DEPTH);
  localparam int c_IDX_W = c_PTR_W - 1;
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_fill;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W-1:0] r_drop_cnt;
  logic [c_XLEN-1:0]  r_fetch_pc;

  logic [c_PTR_W-1:0] w_occ;
  logic [c_PTR_W-1:0] w_pending;
  logic [c_CNT_W-1:0] w_committed;
  logic               w_req;
  logic               w_issue;
  logic               w_valid;
  logic               w_pop;
  logic               w_drop_now;
  logic               w_fill_now;
  logic               w_rsp_counted;
  logic [c_PTR_W-1:0] w_drop_redirect;
  fetch_entry_t       w_head_entry;
  logic               w_unused;

  // Slot accounting: entries in the ring plus stale responses still owed
  always_comb begin
    w_occ         = r_tail - r_head;
    w_pending     = r_tail - r_fill;
    w_committed   = {1'b0, w_occ} + {1'b0, r_drop_cnt};
    w_req         = !reset && !bus.redirect && (w_committed < c_CNT_W'(DEPTH));
    w_issue       = w_req && bus.imem_gnt;
    w_valid       = (r_fill != r_head);
    w_pop         = w_valid && bus.inst_ready && !bus.redirect;
    // Drops are always the oldest responses, so they are consumed first
    w_drop_now    = bus.imem_rvalid && (r_drop_cnt != '0);
    // A response with nothing owed is a protocol violation and is ignored
    w_fill_now    = bus.imem_rvalid && (r_drop_cnt == '0) && (w_pending != '0);
    w_rsp_counted = w_drop_now || w_fill_now;
    // Everything still in flight becomes a drop, minus a response landing now
    w_drop_redirect = r_drop_cnt + w_pending - c_PTR_W'(w_rsp_counted);
  end

  // Pointer, drop counter and fetch-PC state; redirect outranks all traffic
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_drop_cnt <= '0;
      r_fetch_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_drop_cnt <= w_drop_redirect;
      r_fetch_pc <= {bus.redirect_pc[c_XLEN-1:2], 2'b00};
    end else begin
      if (w_issue) begin
        r_tail     <= r_tail + 1'b1;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_fill_now) r_fill     <= r_fill + 1'b1;
      if (w_drop_now) r_drop_cnt <= r_drop_cnt - 1'b1;
      if (w_pop)      r_head     <= r_head + 1'b1;
    end
  end

  fetch_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk          (clk),
    .i_alloc_we   (w_issue),
    .i_alloc_idx  (r_tail[c_IDX_W-1:0]),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill_we    (w_fill_now && !bus.redirect && !reset),
    .i_fill_idx   (r_fill[c_IDX_W-1:0]),
    .i_fill_word  (bus.imem_rdata),
    .i_head_idx   (r_head[c_IDX_W-1:0]),
    .o_head_entry (w_head_entry)
  );

  // Outputs; the head slot is masked to zero whenever it holds nothing valid
  always_comb begin
    bus.imem_req   = w_req;
    bus.imem_addr  = r_fetch_pc;
    bus.inst_valid = w_valid;
    bus.inst       = w_valid ? w_head_entry.word : '0;
    bus.inst_pc    = w_valid ? w_head_entry.pc   : '0;
  end

  // Low redirect address bits are ignored by construction
  assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed bench for fetch_queue with an in-order memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    bit          rst_first;
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    int          exp_iss;
  } vec_t;

  mreq_t mq[$];
  vec_t  vt[23];
  int    cyc       = 0;
  int    lat       = 1;
  int    issue_cnt = 0;
  int    errors    = 0;
  int    checks    = 0;
  bit    gnt_en    = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply this cycle's inputs (called just after a falling edge)
  task automatic drive(input bit rdy, input bit rd, input logic [31:0] rpc);
    bus.inst_ready  = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_gnt    = gnt_en;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    #1;
  endtask

  // Record any issue, then advance one full clock
  task automatic edge_step();
    if (!reset && bus.imem_req && bus.imem_gnt) begin
      mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
      issue_cnt++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mq.delete();
    repeat (2) begin
      drive(1'b0, 1'b0, 32'h0);
      edge_step();
    end
    reset = 1'b0;
    mq.delete();
    issue_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready  = 1'b0;

    // Test 1: streaming, 1-cycle memory, ready held high
    vt[0]  = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  -1};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  -1};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  -1};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  -1};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  -1};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12, -1};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16, -1};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 32'd28, 1'b1, 32'd20, -1};
    // Test 2: ready low for 10 cycles fills the queue, then drains in order
    vt[8]  = '{1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  -1};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 32'd4,  1'b0, 32'd0,  -1};
    vt[10] = '{1'b0, 1'b0, 1'b1, 32'd8,  1'b1, 32'd0,  -1};
    vt[11] = '{1'b0, 1'b0, 1'b1, 32'd12, 1'b1, 32'd0,  -1};
    vt[12] = '{1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0,  -1};
    vt[13] = '{1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0,  -1};
    vt[14] = '{1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0,  -1};
    vt[15] = '{1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0,  -1};
    vt[16] = '{1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0,  -1};
    vt[17] = '{1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0,  -1};
    vt[18] = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd0,   4};
    vt[19] = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd4,  -1};
    vt[20] = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd8,  -1};
    vt[21] = '{1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12, -1};
    vt[22] = '{1'b0, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16, -1};

    @(negedge clk);

    // Reset state
    gnt_en = 1'b1;
    lat    = 1;
    drive(1'b0, 1'b0, 32'h0);
    edge_step();
    drive(1'b0, 1'b0, 32'h0);
    chk("rst_req",    {31'b0, bus.imem_req},   32'd0);
    chk("rst_addr",   bus.imem_addr,           32'h0);
    chk("rst_valid",  {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_inst",   bus.inst,                32'h0);
    chk("rst_instpc", bus.inst_pc,             32'h0);
    edge_step();

    // Table-driven tests 1 and 2
    for (int i = 0; i < 23; i++) begin
      if (vt[i].rst_first) begin
        gnt_en = 1'b1;
        lat    = 1;
        do_reset();
      end
      drive(vt[i].rdy, 1'b0, 32'h0);
      chk($sformatf("vec%0d_req", i),   {31'b0, bus.imem_req},   {31'b0, vt[i].exp_req});
      chk($sformatf("vec%0d_addr", i),  bus.imem_addr,           vt[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.inst_valid}, {31'b0, vt[i].exp_valid});
      chk($sformatf("vec%0d_pc", i),    bus.inst_pc,             vt[i].exp_pc);
      chk($sformatf("vec%0d_inst", i),  bus.inst,
          vt[i].exp_valid ? mem_word(vt[i].exp_pc) : 32'h0);
      if (vt[i].exp_iss >= 0)
        chk($sformatf("vec%0d_issues", i), issue_cnt, vt[i].exp_iss);
      edge_step();
    end

    // Test 3: 3-cycle memory, 3 in flight, redirect to 0x103
    lat = 3;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      chk("s3_issue_addr", bus.imem_addr, 32'(4 * k));
      edge_step();
    end
    drive(1'b1, 1'b1, 32'h0000_0103);
    chk("s3_req_at_redirect", {31'b0, bus.imem_req}, 32'd0);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s3_new_addr", bus.imem_addr, 32'h0000_0100);
    chk("s3_new_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("s3_no_stale", {31'b0, bus.inst_valid}, 32'd0);
    edge_step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      chk("s3_no_stale", {31'b0, bus.inst_valid}, 32'd0);
      edge_step();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      chk("s3_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("s3_pc",    bus.inst_pc, 32'h100 + 32'(4 * k));
      chk("s3_inst",  bus.inst,    mem_word(32'h100 + 32'(4 * k)));
      edge_step();
    end

    // Test 4: redirect coincident with a response and a pop
    lat = 1;
    do_reset();
    repeat (2) begin
      drive(1'b1, 1'b0, 32'h0);
      edge_step();
    end
    drive(1'b1, 1'b1, 32'h0000_0200);
    chk("s4_head_before", bus.inst_pc, 32'h0);
    chk("s4_rvalid_now",  {31'b0, bus.imem_rvalid}, 32'd1);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s4_valid_r1", {31'b0, bus.inst_valid}, 32'd0);
    chk("s4_addr_r1",  bus.imem_addr, 32'h0000_0200);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s4_valid_r2", {31'b0, bus.inst_valid}, 32'd0);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s4_pc_r3", bus.inst_pc, 32'h0000_0200);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s4_pc_r4", bus.inst_pc, 32'h0000_0204);
    edge_step();

    // Test 5: fetch PC wraps past 0xFFFF_FFFC
    lat = 1;
    do_reset();
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    chk("s5_req_at_redirect", {31'b0, bus.imem_req}, 32'd0);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s5_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s5_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s5_addr2", bus.imem_addr, 32'h0000_0000);
    chk("s5_pc0",   bus.inst_pc,   32'hFFFF_FFF8);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s5_pc1", bus.inst_pc, 32'hFFFF_FFFC);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s5_pc2", bus.inst_pc, 32'h0000_0000);
    chk("s5_valid2", {31'b0, bus.inst_valid}, 32'd1);
    edge_step();

    // Test 6: drops fill the budget, then reset mid-operation
    lat = 6;
    do_reset();
    repeat (4) begin
      drive(1'b0, 1'b0, 32'h0);
      edge_step();
    end
    drive(1'b0, 1'b1, 32'h0000_0400);
    chk("s6_req_full", {31'b0, bus.imem_req}, 32'd0);
    edge_step();
    drive(1'b0, 1'b0, 32'h0);
    chk("s6_req_drops_full", {31'b0, bus.imem_req}, 32'd0);
    edge_step();
    reset = 1'b1;
    mq.delete();
    drive(1'b0, 1'b0, 32'h0);
    edge_step();
    drive(1'b0, 1'b0, 32'h0);
    chk("s6_rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("s6_rst_req",   {31'b0, bus.imem_req},   32'd0);
    chk("s6_rst_addr",  bus.imem_addr,           32'h0);
    edge_step();
    reset = 1'b0;
    lat   = 1;
    drive(1'b1, 1'b0, 32'h0);
    chk("s6_post_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("s6_post_addr", bus.imem_addr, 32'h0);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    edge_step();
    drive(1'b1, 1'b0, 32'h0);
    chk("s6_post_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("s6_post_pc",    bus.inst_pc, 32'h0);
    edge_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
